// File: rtl/sram_rw_arbiter.sv
// Round-robin arbiter/sequencer for two requesters sharing one nibble-masked single-port SRAM.
// Optional ARRAY_ARB_INIT_EN: zero-fill the whole array after reset before accepting requests.
module sram_rw_arbiter #(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 40,
    parameter int MASK_W = 10,
    parameter int DEPTH  = 2048
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic [1:0]          req_valid,
    output logic [1:0]          req_ready,
    input  logic [1:0]          req_wmode,
    input  logic [2*ADDR_W-1:0] req_addr,
    input  logic [2*MASK_W-1:0] req_wmask,
    input  logic [2*DATA_W-1:0] req_wdata,
    output logic [1:0]          resp_valid,
    input  logic [1:0]          resp_ready,
    output logic [2*DATA_W-1:0] resp_rdata,
    output logic                sram_en,
    output logic                sram_wmode,
    output logic [ADDR_W-1:0]   sram_addr,
    output logic [MASK_W-1:0]   sram_wmask,
    output logic [DATA_W-1:0]   sram_wdata,
    input  logic [DATA_W-1:0]   sram_rdata,
    output logic                init_done
);

    if (DEPTH > (1 << ADDR_W)) begin : g_depth_check
        $error("DEPTH does not fit in ADDR_W address bits");
    end

    logic              rr_ptr;
    logic [1:0]        inflight;
    logic [1:0]        buf_valid;
    logic [DATA_W-1:0] buf_data [2];
    logic [1:0]        eligible;
    logic [1:0]        grant;
    logic              active;
    logic              init_en;
    logic [ADDR_W-1:0] init_addr;

`ifdef ARRAY_ARB_INIT_EN
    typedef enum logic {INIT, RUN} state_t;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    state_t            state, state_next;
    logic [ADDR_W-1:0] init_cnt, init_cnt_next;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state    <= INIT;
            init_cnt <= '0;
        end else begin
            state    <= state_next;
            init_cnt <= init_cnt_next;
        end
    end

    always_comb begin
        state_next    = state;
        init_cnt_next = init_cnt;
        init_en       = 1'b0;
        if (state == INIT) begin
            // Gate with reset_n so the sweep never touches the macro while held in reset.
            init_en       = reset_n;
            init_cnt_next = init_cnt + 1'b1;
            if (init_cnt == LAST_ADDR)
                state_next = RUN;
        end
    end

    assign init_done = (state == RUN);
    assign init_addr = init_cnt;
`else
    assign init_en   = 1'b0;
    assign init_addr = '0;
    assign init_done = 1'b1;
`endif

    assign active = init_done & reset_n;

    // A read may issue only when its response has somewhere to land two cycles later.
    always_comb begin
        for (int i = 0; i < 2; i++)
            eligible[i] = active & req_valid[i] &
                          (req_wmode[i] | (~inflight[i] & (~buf_valid[i] | resp_ready[i])));
    end

    always_comb begin
        grant = 2'b00;
        if (eligible == 2'b11)
            grant[rr_ptr] = 1'b1;
        else
            grant = eligible;
    end

    assign req_ready = grant;

    always_comb begin
        sram_en    = 1'b0;
        sram_wmode = 1'b0;
        sram_addr  = '0;
        sram_wmask = '0;
        sram_wdata = '0;
        if (init_en) begin
            sram_en    = 1'b1;
            sram_wmode = 1'b1;
            sram_addr  = init_addr;
            sram_wmask = '1;
        end else if (grant != 2'b00) begin
            sram_en    = 1'b1;
            sram_wmode = grant[1] ? req_wmode[1] : req_wmode[0];
            sram_addr  = grant[1] ? req_addr[2*ADDR_W-1:ADDR_W]  : req_addr[ADDR_W-1:0];
            sram_wmask = grant[1] ? req_wmask[2*MASK_W-1:MASK_W] : req_wmask[MASK_W-1:0];
            sram_wdata = grant[1] ? req_wdata[2*DATA_W-1:DATA_W] : req_wdata[DATA_W-1:0];
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rr_ptr      <= 1'b0;
            inflight    <= 2'b00;
            buf_valid   <= 2'b00;
            buf_data[0] <= '0;
            buf_data[1] <= '0;
        end else begin
            // After any grant the other requester gets priority.
            if (grant != 2'b00)
                rr_ptr <= ~grant[1];
            for (int i = 0; i < 2; i++) begin
                inflight[i] <= grant[i] & ~req_wmode[i];
                if (inflight[i]) begin
                    buf_valid[i] <= 1'b1;
                    buf_data[i]  <= sram_rdata;
                end else if (buf_valid[i] & resp_ready[i]) begin
                    buf_valid[i] <= 1'b0;
                end
            end
        end
    end

    assign resp_valid = buf_valid;
    assign resp_rdata = {buf_data[1], buf_data[0]};

endmodule

// File: tb/tb_sram_rw_arbiter.sv
// Scoreboard bench for sram_rw_arbiter with a behavioural nibble-masked SRAM model.
module tb_sram_rw_arbiter;

    logic        clock = 1'b0;
    logic        reset_n;
    logic [1:0]  req_valid, req_ready, req_wmode;
    logic [21:0] req_addr;
    logic [19:0] req_wmask;
    logic [79:0] req_wdata;
    logic [1:0]  resp_valid, resp_ready;
    logic [79:0] resp_rdata;
    logic        sram_en, sram_wmode;
    logic [10:0] sram_addr;
    logic [9:0]  sram_wmask;
    logic [39:0] sram_wdata;
    logic [39:0] sram_rdata;
    logic        init_done;

    logic [39:0] mem [2048];
    logic [39:0] q0 [$];
    logic [39:0] q1 [$];
    int checks = 0;
    int errors = 0;

    sram_rw_arbiter dut (
        .clock(clock), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_wmode(req_wmode),
        .req_addr(req_addr), .req_wmask(req_wmask), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
        .sram_en(sram_en), .sram_wmode(sram_wmode), .sram_addr(sram_addr),
        .sram_wmask(sram_wmask), .sram_wdata(sram_wdata), .sram_rdata(sram_rdata),
        .init_done(init_done)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (sram_en) begin
            if (sram_wmode) begin
                for (int k = 0; k < 10; k++)
                    if (sram_wmask[k]) mem[sram_addr][k*4 +: 4] <= sram_wdata[k*4 +: 4];
            end else begin
                sram_rdata <= mem[sram_addr];
            end
        end
    end

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Monitor: every accepted response is matched against the scoreboard queue.
    always @(negedge clock) begin
        if (reset_n && resp_valid[0] && resp_ready[0]) begin
            if (q0.size() == 0) check("resp0_unexpected", 1, 0);
            else check("resp0_data", resp_rdata[39:0], q0.pop_front());
        end
        if (reset_n && resp_valid[1] && resp_ready[1]) begin
            if (q1.size() == 0) check("resp1_unexpected", 1, 0);
            else check("resp1_data", resp_rdata[79:40], q1.pop_front());
        end
    end

    task automatic set_req(int r, bit v, bit wm, logic [10:0] a, logic [9:0] m, logic [39:0] d);
        req_valid[r]         = v;
        req_wmode[r]         = wm;
        req_addr[r*11 +: 11] = a;
        req_wmask[r*10 +: 10] = m;
        req_wdata[r*40 +: 40] = d;
    endtask

    task automatic push(int r, logic [39:0] exp);
        if (r == 0) q0.push_back(exp);
        else q1.push_back(exp);
    endtask

    task automatic issue(string name, int r, bit wm, logic [10:0] a, logic [9:0] m,
                         logic [39:0] d, logic [39:0] exp);
        bit acc = 1'b0;
        set_req(r, 1'b1, wm, a, m, d);
        for (int k = 0; k < 20 && !acc; k++) begin
            @(negedge clock);
            if (req_ready[r]) begin
                acc = 1'b1;
                if (!wm) push(r, exp);
            end
            @(posedge clock); #1;
        end
        req_valid[r] = 1'b0;
        check(name, acc, 1);
    endtask

    task automatic wait_init();
`ifdef ARRAY_ARB_INIT_EN
        int n = 0;
        int bad = 0;
        int k = 0;
        while (!init_done && k < 3000) begin
            @(negedge clock);
            if (!init_done && sram_en) begin
                if (sram_addr != n[10:0] || !sram_wmode || sram_wmask != 10'h3FF ||
                    sram_wdata != 40'h0 || req_ready != 2'b00) bad++;
                n++;
            end
            k++;
        end
        check("init_writes", n, 2048);
        check("init_fields", bad, 0);
        check("init_done", init_done, 1);
        @(posedge clock); #1;
`else
        check("init_done", init_done, 1);
`endif
    endtask

    initial begin
        reset_n    = 1'b0;
        req_valid  = 2'b00;
        req_wmode  = 2'b00;
        req_addr   = '0;
        req_wmask  = '0;
        req_wdata  = '0;
        resp_ready = 2'b11;
        set_req(0, 1'b1, 1'b1, 11'h7, 10'h3FF, 40'h1);

        // Reset state, with a write request held to prove the macro stays disabled.
        repeat (2) @(posedge clock);
        @(negedge clock);
        check("rst_req_ready", req_ready, 2'b00);
        check("rst_resp_valid", resp_valid, 2'b00);
        check("rst_sram_en", sram_en, 0);
`ifdef ARRAY_ARB_INIT_EN
        check("rst_init_done", init_done, 0);
`else
        check("rst_init_done", init_done, 1);
`endif
        @(posedge clock); #1;
        req_valid = 2'b00;
        reset_n   = 1'b1;
        wait_init();

        // Write then read back in consecutive cycles; response two cycles after accept.
        issue("wr0_acc", 0, 1'b1, 11'h155, 10'h3FF, 40'hA5A5A5A5A5, 40'h0);
        issue("rd0_acc", 0, 1'b0, 11'h155, 10'h000, 40'h0, 40'hA5A5A5A5A5);
        @(negedge clock);
        check("rd0_lat_t1", resp_valid[0], 0);
        @(negedge clock);
        check("rd0_lat_t2", resp_valid[0], 1);
        @(posedge clock); #1;

        // Partial nibble mask.
        issue("wr1_full", 1, 1'b1, 11'h02A, 10'h3FF, 40'hFFFFFFFFFF, 40'h0);
        issue("wr1_part", 1, 1'b1, 11'h02A, 10'h001, 40'h0000000003, 40'h0);
        issue("rd1_part", 1, 1'b0, 11'h02A, 10'h000, 40'h0, 40'hFFFFFFFFF3);
        repeat (3) @(posedge clock); #1;

        // Contending writers alternate every cycle, starting with requester 0.
        set_req(0, 1'b1, 1'b1, 11'h100, 10'h3FF, 40'h11);
        set_req(1, 1'b1, 1'b1, 11'h101, 10'h3FF, 40'h22);
        for (int k = 0; k < 6; k++) begin
            @(negedge clock);
            check("rr_sram_en", sram_en, 1);
            check("rr_grant", req_ready, (k % 2 == 0) ? 2'b01 : 2'b10);
            @(posedge clock); #1;
        end
        req_valid = 2'b00;

        // Backpressure on requester 1 while requester 0 keeps writing.
        resp_ready[1] = 1'b0;
        set_req(1, 1'b1, 1'b0, 11'h155, 10'h000, 40'h0);
        @(negedge clock);
        check("bp_acc", req_ready, 2'b10);
        if (req_ready[1]) push(1, 40'hA5A5A5A5A5);
        @(posedge clock); #1;
        set_req(1, 1'b1, 1'b0, 11'h02A, 10'h000, 40'h0);
        set_req(0, 1'b1, 1'b1, 11'h300, 10'h3FF, 40'h123);
        for (int k = 0; k < 6; k++) begin
            @(negedge clock);
            check("bp_ready", req_ready, 2'b01);
            if (k > 0) begin
                check("bp_valid", resp_valid[1], 1);
                check("bp_hold", resp_rdata[79:40], 40'hA5A5A5A5A5);
            end
            @(posedge clock); #1;
        end
        resp_ready[1] = 1'b1;
        @(negedge clock);
        check("bp_drain_acc", req_ready, 2'b10);
        if (req_ready[1]) push(1, 40'hFFFFFFFFF3);
        @(posedge clock); #1;
        req_valid = 2'b00;
        repeat (4) @(posedge clock); #1;

        // Reset right after a read is accepted: no response, pointer back to 0.
        set_req(0, 1'b1, 1'b0, 11'h155, 10'h000, 40'h0);
        @(negedge clock);
        check("rstmid_acc", req_ready, 2'b01);
        @(posedge clock); #1;
        reset_n = 1'b0;
        @(negedge clock);
        check("rstmid_sram_en", sram_en, 0);
        check("rstmid_ready", req_ready, 2'b00);
        @(posedge clock); #1;
        reset_n   = 1'b1;
        req_valid = 2'b00;
        wait_init();
        for (int k = 0; k < 4; k++) begin
            @(negedge clock);
            check("rstmid_no_resp", resp_valid, 2'b00);
            @(posedge clock); #1;
        end
        set_req(0, 1'b1, 1'b1, 11'h200, 10'h3FF, 40'h5);
        set_req(1, 1'b1, 1'b1, 11'h201, 10'h3FF, 40'h6);
        @(negedge clock);
        check("rstmid_rr_ptr", req_ready, 2'b01);
        @(posedge clock); #1;
        req_valid = 2'b00;

        repeat (3) @(posedge clock);
        check("q0_drained", q0.size(), 0);
        check("q1_drained", q1.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sram_rw_arbiter.md
Name: sram_rw_arbiter

Overview:
Two-requester arbiter and sequencer for one single-port, nibble-masked SRAM macro (2048 x 40, 1-cycle registered-address read).
Grants at most one access per cycle with round-robin fairness.
Returns read data through a per-requester 1-entry response buffer with backpressure.
Sits between cache-side requesters and the array macro; the macro itself is instantiated outside this block.

Parameters:
ADDR_W, 11, SRAM address width
DATA_W, 40, SRAM data width
MASK_W, 10, write-mask width; each bit covers DATA_W/MASK_W (=4) data bits
DEPTH, 2048, number of SRAM entries; used only by the init sweep

Ports:
clock  in  1  single clock, rising edge
reset_n  in  1  asynchronous active-low reset
req_valid  in  2  per-requester request valid; bit i = requester i
req_ready  out  2  per-requester accept; a transfer occurs when valid&ready
req_wmode  in  2  per requester: 1 = write, 0 = read
req_addr  in  2*ADDR_W  per-requester address; requester i at [i*ADDR_W +: ADDR_W]
req_wmask  in  2*MASK_W  per-requester nibble write mask
req_wdata  in  2*DATA_W  per-requester write data
resp_valid  out  2  read response valid
resp_ready  in  2  read response accept
resp_rdata  out  2*DATA_W  read response data, held stable while valid&!ready
sram_en  out  1  macro enable
sram_wmode  out  1  macro write mode
sram_addr  out  ADDR_W  macro address
sram_wmask  out  MASK_W  macro write mask
sram_wdata  out  DATA_W  macro write data
sram_rdata  in  DATA_W  macro read data, valid the cycle after a read enable
init_done  out  1  high once the block is accepting requests

Behaviour:
- Reset values (asynchronous, reset_n=0):
  - req_ready=0, resp_valid=0, sram_en=0, RR pointer=0, all in-flight flags and response buffers cleared.
  - init_done=0 with ARRAY_ARB_INIT_EN; init_done=1 without it.
- Eligibility of requester i (only when init_done=1):
  - Write: always eligible.
  - Read: eligible only if no read is in flight for i, and resp buffer i is empty or is being drained this cycle (resp_valid[i]&resp_ready[i]).
- Arbitration:
  - Both eligible: grant goes to the RR pointer; pointer moves to the other requester after that grant.
  - One eligible: it wins; pointer moves to the other requester.
  - No grant: pointer unchanged.
- req_ready[i] = eligible(i) & grant(i). It is combinational from req_valid, so requesters must not make valid depend on ready.
- sram_* outputs are combinational copies of the granted request. sram_en=1 only in a grant cycle. Macro fields are don't-care when sram_en=0; drive them 0.
- Read latency:
  - Accept in cycle T; sram_rdata is sampled at the end of T+1 into resp buffer i; resp_valid[i]=1 from T+2.
  - Maximum throughput: one read per 2 cycles per requester, or 1 access per cycle across both requesters.
- Response buffer: cleared on valid&ready. resp_rdata stays constant while pending.
- Writes produce no response. Write then read to the same address in consecutive cycles returns the new data; the macro is write-before-read across cycles, so no bypass is needed.
- Same-cycle read and write from the two requesters: only one is granted. The loser retries; no merge.
- Reset mid-read: in-flight read is dropped; no response appears after reset release.
- The macro is never enabled while reset_n=0.

Optional Feature:
ARRAY_ARB_INIT_EN
- Defined: after reset release, FSM INIT -> RUN.
  - In INIT, issue one write per cycle with sram_wmode=1, full mask (all ones) and data 0, to addresses 0..DEPTH-1 in ascending order, with req_ready=0.
  - After the write to DEPTH-1, go to RUN. init_done rises the cycle after the last init write.
  - Total: DEPTH cycles of sram_en, then init_done=1.
- Not defined: no INIT state; the block starts in RUN and init_done is tied 1.

Test Plan:
- Init (macro defined) -> exactly 2048 consecutive writes, addresses 0..2047, wmask=0x3FF, wdata=0; init_done=1 at cycle 2049; req_ready=0 throughout.
- Req0 writes addr 0x155, mask 0x3FF, data 0xA5A5A5A5A5; next cycle req0 reads 0x155 -> resp_valid[0] two cycles after accept with 0xA5A5A5A5A5.
- Partial mask: write 0xFFFFFFFFFF, then mask 0x001 data 0x0000000003 -> read returns 0xFFFFFFFFF3.
- Both requesters hold writes continuously -> grants alternate 0,1,0,1; sram_en high every cycle; neither starves.
- Req1 read with resp_ready[1]=0 for 5 cycles -> resp_rdata stable; second req1 read not accepted until the drain cycle; req0 traffic unaffected.
- Assert reset_n low the cycle after a read is accepted -> no resp_valid after release; RR pointer back to 0.
